// File: rtl/pipe_mem_arbiter_pkg.sv
// Shared LC-3b types for the memory arbiter: word/mask typedefs, FSM state
// encoding and the round-robin pick helper.
package pipe_mem_arbiter_pkg;

    typedef logic [15:0] lc3b_word;
    typedef logic [1:0]  lc3b_mem_wmask;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_GNT_I = 2'd1,
        ARB_GNT_D = 2'd2
    } arb_state_t;

    localparam logic LAST_GNT_I = 1'b0;
    localparam logic LAST_GNT_D = 1'b1;

    // On a tie the port that was not served last wins.
    function automatic arb_state_t arb_pick(input logic i_req,
                                            input logic d_req,
                                            input logic last_gnt);
        arb_state_t pick;
        if (i_req && d_req) begin
            pick = (last_gnt == LAST_GNT_D) ? ARB_GNT_I : ARB_GNT_D;
        end else if (i_req) begin
            pick = ARB_GNT_I;
        end else if (d_req) begin
            pick = ARB_GNT_D;
        end else begin
            pick = ARB_IDLE;
        end
        return pick;
    endfunction

endpackage

// File: rtl/pipe_mem_arbiter_sat_counter.sv
// Saturating up-counter used for the optional per-port stall statistics.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_inc,
    output logic [W-1:0] o_count
);

    logic [W-1:0] r_count;

    // Count up on i_inc, holding at all-ones.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_inc && (r_count != '1)) begin
            r_count <= r_count + {{(W-1){1'b0}}, 1'b1};
        end else begin
            r_count <= r_count;
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/pipe_mem_arbiter.sv
// Round-robin arbiter muxing the LC-3b fetch and data memory ports onto one
// physical memory port. Optional stall counters: define PIPE_MEM_ARB_STATS_EN.
module pipe_mem_arbiter
    import pipe_mem_arbiter_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_mem_read,
    input  lc3b_word      i_mem_address,
    output lc3b_word      i_mem_rdata,
    output logic          i_mem_resp,
    input  logic          d_mem_read,
    input  logic          d_mem_write,
    input  lc3b_mem_wmask d_mem_byte_enable,
    input  lc3b_word      d_mem_address,
    input  lc3b_word      d_mem_wdata,
    output lc3b_word      d_mem_rdata,
    output logic          d_mem_resp,
    output logic          pmem_read,
    output logic          pmem_write,
    output lc3b_mem_wmask pmem_byte_enable,
    output lc3b_word      pmem_address,
    output lc3b_word      pmem_wdata,
    input  lc3b_word      pmem_rdata,
    input  logic          pmem_resp
`ifdef PIPE_MEM_ARB_STATS_EN
    ,
    output logic [CNT_W-1:0] stat_i_stall,
    output logic [CNT_W-1:0] stat_d_stall
`endif
);

    arb_state_t r_state;
    arb_state_t w_next_state;
    logic       r_last_gnt;
    logic       w_next_last_gnt;
    logic       w_i_req;
    logic       w_d_req;

    assign w_i_req = i_mem_read;
    assign w_d_req = d_mem_read | d_mem_write;

    // State and round-robin history; reset leaves last_gnt on D so I wins the first tie.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ARB_IDLE;
            r_last_gnt <= LAST_GNT_D;
        end else begin
            r_state    <= w_next_state;
            r_last_gnt <= w_next_last_gnt;
        end
    end

    // Next-state and port muxing; outputs derive from state so reset clears them at once.
    always_comb begin
        w_next_state     = r_state;
        w_next_last_gnt  = r_last_gnt;
        pmem_read        = 1'b0;
        pmem_write       = 1'b0;
        pmem_byte_enable = 2'b00;
        pmem_address     = 16'h0000;
        pmem_wdata       = 16'h0000;
        i_mem_resp       = 1'b0;
        i_mem_rdata      = 16'h0000;
        d_mem_resp       = 1'b0;
        d_mem_rdata      = 16'h0000;
        case (r_state)
            ARB_IDLE: begin
                w_next_state = arb_pick(w_i_req, w_d_req, r_last_gnt);
            end
            ARB_GNT_I: begin
                pmem_read    = i_mem_read;
                pmem_address = i_mem_address;
                if (pmem_resp) begin
                    i_mem_resp      = 1'b1;
                    i_mem_rdata     = pmem_rdata;
                    w_next_state    = ARB_IDLE;
                    w_next_last_gnt = LAST_GNT_I;
                end else begin
                    w_next_state = ARB_GNT_I;
                end
            end
            ARB_GNT_D: begin
                // A simultaneous read+write is served as a write.
                pmem_read        = d_mem_read & ~d_mem_write;
                pmem_write       = d_mem_write;
                pmem_byte_enable = d_mem_byte_enable;
                pmem_address     = d_mem_address;
                pmem_wdata       = d_mem_wdata;
                if (pmem_resp) begin
                    d_mem_resp      = 1'b1;
                    d_mem_rdata     = pmem_rdata;
                    w_next_state    = ARB_IDLE;
                    w_next_last_gnt = LAST_GNT_D;
                end else begin
                    w_next_state = ARB_GNT_D;
                end
            end
            default: begin
                w_next_state = ARB_IDLE;
            end
        endcase
    end

`ifdef PIPE_MEM_ARB_STATS_EN
    logic w_i_stall;
    logic w_d_stall;

    assign w_i_stall = w_i_req & ~i_mem_resp;
    assign w_d_stall = w_d_req & ~d_mem_resp;

    sat_counter #(.W(CNT_W)) u_i_stall_cnt (
        .clk     (clk),
        .rst     (rst),
        .i_inc   (w_i_stall),
        .o_count (stat_i_stall)
    );

    sat_counter #(.W(CNT_W)) u_d_stall_cnt (
        .clk     (clk),
        .rst     (rst),
        .i_inc   (w_d_stall),
        .o_count (stat_d_stall)
    );
`endif

endmodule

// File: tb/tb_pipe_mem_arbiter.sv
// Directed self-checking bench for pipe_mem_arbiter; inputs change and outputs
// are checked around the falling edge, state advances on the rising edge.
module tb_pipe_mem_arbiter;

    logic        clk;
    logic        rst;
    logic        i_mem_read;
    logic [15:0] i_mem_address;
    logic [15:0] i_mem_rdata;
    logic        i_mem_resp;
    logic        d_mem_read;
    logic        d_mem_write;
    logic [1:0]  d_mem_byte_enable;
    logic [15:0] d_mem_address;
    logic [15:0] d_mem_wdata;
    logic [15:0] d_mem_rdata;
    logic        d_mem_resp;
    logic        pmem_read;
    logic        pmem_write;
    logic [1:0]  pmem_byte_enable;
    logic [15:0] pmem_address;
    logic [15:0] pmem_wdata;
    logic [15:0] pmem_rdata;
    logic        pmem_resp;
`ifdef PIPE_MEM_ARB_STATS_EN
    logic [3:0]  stat_i_stall;
    logic [3:0]  stat_d_stall;
`endif

    int total_cnt;
    int bad_cnt;

    pipe_mem_arbiter #(.CNT_W(4)) dut (
        .clk               (clk),
        .rst               (rst),
        .i_mem_read        (i_mem_read),
        .i_mem_address     (i_mem_address),
        .i_mem_rdata       (i_mem_rdata),
        .i_mem_resp        (i_mem_resp),
        .d_mem_read        (d_mem_read),
        .d_mem_write       (d_mem_write),
        .d_mem_byte_enable (d_mem_byte_enable),
        .d_mem_address     (d_mem_address),
        .d_mem_wdata       (d_mem_wdata),
        .d_mem_rdata       (d_mem_rdata),
        .d_mem_resp        (d_mem_resp),
        .pmem_read         (pmem_read),
        .pmem_write        (pmem_write),
        .pmem_byte_enable  (pmem_byte_enable),
        .pmem_address      (pmem_address),
        .pmem_wdata        (pmem_wdata),
        .pmem_rdata        (pmem_rdata),
        .pmem_resp         (pmem_resp)
`ifdef PIPE_MEM_ARB_STATS_EN
        ,
        .stat_i_stall      (stat_i_stall),
        .stat_d_stall      (stat_d_stall)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total_cnt = total_cnt + 1;
        if (got !== exp) begin
            bad_cnt = bad_cnt + 1;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic clear_inputs();
        i_mem_read        = 1'b0;
        i_mem_address     = 16'h0000;
        d_mem_read        = 1'b0;
        d_mem_write       = 1'b0;
        d_mem_byte_enable = 2'b00;
        d_mem_address     = 16'h0000;
        d_mem_wdata       = 16'h0000;
        pmem_rdata        = 16'h0000;
        pmem_resp         = 1'b0;
    endtask

    // Advance to the next falling edge, where stimulus changes.
    task automatic next_cyc();
        @(negedge clk);
    endtask

    task automatic check_quiet(input string tag);
        check_val({tag, "_rd"},   {31'd0, pmem_read},  32'd0);
        check_val({tag, "_wr"},   {31'd0, pmem_write}, 32'd0);
        check_val({tag, "_iresp"}, {31'd0, i_mem_resp}, 32'd0);
        check_val({tag, "_dresp"}, {31'd0, d_mem_resp}, 32'd0);
    endtask

    initial begin
        total_cnt = 0;
        bad_cnt   = 0;
        rst       = 1'b1;
        clear_inputs();

        // Reset state
        next_cyc();
        next_cyc();
        #1;
        check_quiet("rst");
        check_val("rst_be",    {30'd0, pmem_byte_enable}, 32'd0);
        check_val("rst_addr",  {16'd0, pmem_address},     32'd0);
        check_val("rst_wdata", {16'd0, pmem_wdata},       32'd0);
        check_val("rst_irdata", {16'd0, i_mem_rdata},     32'd0);
        check_val("rst_drdata", {16'd0, d_mem_rdata},     32'd0);

        // Single I read, memory answers on the third strobe cycle
        rst           = 1'b0;
        i_mem_read    = 1'b1;
        i_mem_address = 16'h0010;
        #1;
        check_quiet("t1_idle");
        for (int c = 1; c <= 3; c++) begin
            next_cyc();
            if (c == 3) begin
                pmem_resp  = 1'b1;
                pmem_rdata = 16'h1234;
            end
            #1;
            check_val($sformatf("t1_rd%0d", c),   {31'd0, pmem_read},    32'd1);
            check_val($sformatf("t1_addr%0d", c), {16'd0, pmem_address}, 32'h0010);
            check_val($sformatf("t1_iresp%0d", c), {31'd0, i_mem_resp},  (c == 3) ? 32'd1 : 32'd0);
            check_val($sformatf("t1_dresp%0d", c), {31'd0, d_mem_resp},  32'd0);
        end
        check_val("t1_irdata", {16'd0, i_mem_rdata}, 32'h1234);
        next_cyc();
        clear_inputs();
        #1;
        check_quiet("t1_after");

        // Both requesting from reset: I first, turnaround, then D write
        rst = 1'b1;
        #1;
        rst               = 1'b0;
        i_mem_read        = 1'b1;
        i_mem_address     = 16'h0020;
        d_mem_write       = 1'b1;
        d_mem_address     = 16'h0100;
        d_mem_wdata       = 16'hBEEF;
        d_mem_byte_enable = 2'b11;
        #1;
        check_quiet("t2_idle");
        next_cyc();
        pmem_resp  = 1'b1;
        pmem_rdata = 16'h0A0A;
        #1;
        check_val("t2_i_rd",    {31'd0, pmem_read},        32'd1);
        check_val("t2_i_wr",    {31'd0, pmem_write},       32'd0);
        check_val("t2_i_addr",  {16'd0, pmem_address},     32'h0020);
        check_val("t2_i_be",    {30'd0, pmem_byte_enable}, 32'd0);
        check_val("t2_i_resp",  {31'd0, i_mem_resp},       32'd1);
        check_val("t2_i_dresp", {31'd0, d_mem_resp},       32'd0);
        check_val("t2_i_drdata", {16'd0, d_mem_rdata},     32'd0);
        next_cyc();
        i_mem_read = 1'b0;
        pmem_resp  = 1'b0;
        #1;
        check_quiet("t2_turn");
        next_cyc();
        pmem_resp = 1'b1;
        #1;
        check_val("t2_d_wr",    {31'd0, pmem_write},       32'd1);
        check_val("t2_d_rd",    {31'd0, pmem_read},        32'd0);
        check_val("t2_d_addr",  {16'd0, pmem_address},     32'h0100);
        check_val("t2_d_wdata", {16'd0, pmem_wdata},       32'hBEEF);
        check_val("t2_d_be",    {30'd0, pmem_byte_enable}, 32'd3);
        check_val("t2_d_resp",  {31'd0, d_mem_resp},       32'd1);
        check_val("t2_d_iresp", {31'd0, i_mem_resp},       32'd0);
        next_cyc();
        clear_inputs();

        // Continuous contention, 1-cycle memory, pmem_resp also high in IDLE
        i_mem_read    = 1'b1;
        i_mem_address = 16'h0030;
        d_mem_read    = 1'b1;
        d_mem_address = 16'h0300;
        pmem_resp     = 1'b1;
        for (int k = 0; k < 12; k++) begin
            pmem_rdata = 16'h5A00 + 16'(k);
            #1;
            if ((k % 2) == 0) begin
                check_quiet($sformatf("t3_idle%0d", k));
            end else begin
                logic exp_i;
                exp_i = (((k - 1) / 2) % 2) == 0;
                check_val($sformatf("t3_iresp%0d", k), {31'd0, i_mem_resp}, {31'd0, exp_i});
                check_val($sformatf("t3_dresp%0d", k), {31'd0, d_mem_resp}, {31'd0, ~exp_i});
                check_val($sformatf("t3_irdata%0d", k), {16'd0, i_mem_rdata},
                          exp_i ? {16'd0, 16'h5A00 + 16'(k)} : 32'd0);
                check_val($sformatf("t3_drdata%0d", k), {16'd0, d_mem_rdata},
                          exp_i ? 32'd0 : {16'd0, 16'h5A00 + 16'(k)});
            end
            next_cyc();
        end
        clear_inputs();
        next_cyc();

        // Byte write to D, then an I grant with the mask cleared
        d_mem_write       = 1'b1;
        d_mem_byte_enable = 2'b01;
        d_mem_address     = 16'h0201;
        d_mem_wdata       = 16'h00AB;
        next_cyc();
        i_mem_read    = 1'b1;
        i_mem_address = 16'h0040;
        pmem_resp     = 1'b1;
        #1;
        check_val("t4_be",    {30'd0, pmem_byte_enable}, 32'd1);
        check_val("t4_addr",  {16'd0, pmem_address},     32'h0201);
        check_val("t4_wr",    {31'd0, pmem_write},       32'd1);
        check_val("t4_dresp", {31'd0, d_mem_resp},       32'd1);
        next_cyc();
        d_mem_write = 1'b0;
        pmem_resp   = 1'b0;
        #1;
        check_quiet("t4_turn");
        next_cyc();
        pmem_resp = 1'b1;
        #1;
        check_val("t4_i_be",   {30'd0, pmem_byte_enable}, 32'd0);
        check_val("t4_i_rd",   {31'd0, pmem_read},        32'd1);
        check_val("t4_i_addr", {16'd0, pmem_address},     32'h0040);
        check_val("t4_i_resp", {31'd0, i_mem_resp},       32'd1);
        next_cyc();
        clear_inputs();
        next_cyc();

        // Reset during an outstanding D write, then a clean retry
        d_mem_write       = 1'b1;
        d_mem_byte_enable = 2'b11;
        d_mem_address     = 16'h0400;
        d_mem_wdata       = 16'h1111;
        next_cyc();
        #1;
        check_val("t5_wr_pre", {31'd0, pmem_write}, 32'd1);
        rst = 1'b1;
        #1;
        check_val("t5_wr_async", {31'd0, pmem_write}, 32'd0);
        check_val("t5_dresp",    {31'd0, d_mem_resp}, 32'd0);
        next_cyc();
        #1;
        check_val("t5_dresp_hold", {31'd0, d_mem_resp}, 32'd0);
        rst = 1'b0;
        #1;
        check_quiet("t5_idle");
        next_cyc();
        pmem_resp = 1'b1;
        #1;
        check_val("t5_retry_wr",   {31'd0, pmem_write},   32'd1);
        check_val("t5_retry_addr", {16'd0, pmem_address}, 32'h0400);
        check_val("t5_retry_resp", {31'd0, d_mem_resp},   32'd1);
        next_cyc();
        clear_inputs();
        next_cyc();

`ifdef PIPE_MEM_ARB_STATS_EN
        // Stall counter saturation and clear
        rst = 1'b1;
        #1;
        rst = 1'b0;
        check_val("t6_init", {28'd0, stat_i_stall}, 32'd0);
        i_mem_read    = 1'b1;
        i_mem_address = 16'h0050;
        for (int n = 1; n <= 20; n++) begin
            next_cyc();
            #1;
            if (n == 3 || n == 15 || n == 20) begin
                check_val($sformatf("t6_istall%0d", n), {28'd0, stat_i_stall},
                          (n < 15) ? n : 32'd15);
            end
        end
        check_val("t6_dstall", {28'd0, stat_d_stall}, 32'd0);
        rst = 1'b1;
        #1;
        check_val("t6_clear", {28'd0, stat_i_stall}, 32'd0);
        rst = 1'b0;
        clear_inputs();
        next_cyc();
`endif

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule
